// File: rtl/regfile_write_buffer_if.sv
// Enqueue handshake between the write-back path (master) and regfile_write_buffer (slave).
interface regfile_write_buffer_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  modport master (output in_valid, output in_addr, output in_data, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/regfile_write_buffer.sv
// In-order write-back FIFO feeding the register file write port, with youngest-match
// read bypass compiled in only when WB_BYPASS_EN is defined.
module regfile_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  regfile_write_buffer_if.slave    s_in,
  input  logic                     drain_stall,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  input  logic [AW-1:0]            lookup_a,
  input  logic [AW-1:0]            lookup_b,
  output logic                     hit_a,
  output logic                     hit_b,
  output logic [DW-1:0]            hit_data_a,
  output logic [DW-1:0]            hit_data_b,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

  assign wr_en   = !empty && !drain_stall;
  assign wr_addr = empty ? '0 : r_addr[r_head];
  assign wr_data = empty ? '0 : r_data[r_head];

`ifdef WB_BYPASS_EN
  assign s_in.in_ready = !full;
`else
  // Without a bypass only one write may be in flight so reads stay coherent.
  assign s_in.in_ready = empty && !wr_en;
`endif

  // Writes to r0 complete the handshake but are never stored.
  assign w_push = s_in.in_valid && s_in.in_ready && (s_in.in_addr != '0);
  assign w_pop  = wr_en;

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= s_in.in_addr;
      r_data[r_tail] <= s_in.in_data;
    end
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] w_idx;

  // Scan oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit_a      = 1'b0;
    hit_b      = 1'b0;
    hit_data_a = '0;
    hit_data_b = '0;
    w_idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (CW'(i) < r_count) begin
        if ((lookup_a != '0) && (r_addr[w_idx] == lookup_a)) begin
          hit_a      = 1'b1;
          hit_data_a = r_data[w_idx];
        end
        if ((lookup_b != '0) && (r_addr[w_idx] == lookup_b)) begin
          hit_b      = 1'b1;
          hit_data_b = r_data[w_idx];
        end
      end
    end
  end
`else
  logic w_unused_lookup;

  assign w_unused_lookup = ^{lookup_a, lookup_b};
  assign hit_a      = 1'b0;
  assign hit_b      = 1'b0;
  assign hit_data_a = '0;
  assign hit_data_b = '0;
`endif

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Scoreboard bench for regfile_write_buffer; bypass-only scenarios are built when WB_BYPASS_EN is defined.
module tb_regfile_write_buffer;

  logic        clk;
  logic        rst_n;
  logic        drain_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  lookup_a;
  logic [4:0]  lookup_b;
  logic        hit_a;
  logic        hit_b;
  logic [31:0] hit_data_a;
  logic [31:0] hit_data_b;
  logic [2:0]  count;
  logic        empty;
  logic        full;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_write_buffer_if #(.AW(5), .DW(32)) u_if ();

  regfile_write_buffer #(.DEPTH(4), .AW(5), .DW(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_in        (u_if),
    .drain_stall (drain_stall),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .lookup_a    (lookup_a),
    .lookup_b    (lookup_b),
    .hit_a       (hit_a),
    .hit_b       (hit_b),
    .hit_data_a  (hit_data_a),
    .hit_data_b  (hit_data_b),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [36:0] sb [$];
  logic [31:0] rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file model captures the write on the same edge as the drain.
  always @(posedge clk) begin
    if (rst_n && wr_en) rf[wr_addr] <= wr_data;
  end

  // Monitor: every drain cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain_unexpected: got addr %0d data %0d expected no drain", wr_addr, wr_data);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("drain_addr", 64'(wr_addr), 64'(e[36:32]));
        chk("drain_data", 64'(wr_data), 64'(e[31:0]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_addr  = a;
    u_if.in_data  = d;
    if (a != 5'd0) sb.push_back({a, d});
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = u_if.in_ready;
      @(posedge clk);
      #1;
    end
    u_if.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: got no in_ready for r%0d expected acceptance", a);
      if (a != 5'd0) void'(sb.pop_back());
    end
  endtask

  task automatic wait_empty();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (empty && sb.size() == 0) done = 1'b1;
      else tick(1);
    end
    chk("wait_empty", 64'(done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    drain_stall = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_addr = '0;
    u_if.in_data = '0;
    lookup_a = 5'd2;
    lookup_b = 5'd0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    tick(2);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_in_ready", 64'(u_if.in_ready), 64'd1);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr_data", 64'({wr_addr, wr_data}), 64'd0);
    chk("rst_hit_a", 64'({hit_a, hit_data_a}), 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Single write r2=42: drains the cycle after enqueue.
    push(5'd2, 32'd42);
    chk("w1_wr_en", 64'(wr_en), 64'd1);
    chk("w1_wr_addr", 64'(wr_addr), 64'd2);
    chk("w1_wr_data", 64'(wr_data), 64'd42);
    chk("w1_count", 64'(count), 64'd1);
    chk("w1_in_ready", 64'(u_if.in_ready), 64'(BYP));
    chk("w1_hit_a", 64'({hit_a, hit_data_a}), BYP ? {31'd0, 1'b1, 32'd42} : 64'd0);
    tick(1);
    chk("w1_rf", 64'(rf[2]), 64'd42);
    chk("w1_count_after", 64'(count), 64'd0);
    chk("w1_empty_after", 64'(empty), 64'd1);

    // Stall holds the entry in place.
    drain_stall = 1'b1;
    push(5'd5, 32'd7);
    tick(3);
    chk("stall_count", 64'(count), 64'd1);
    chk("stall_wr_en", 64'(wr_en), 64'd0);
    chk("stall_in_ready", 64'(u_if.in_ready), 64'(BYP));
    drain_stall = 1'b0;
    #1;
    chk("stall_release_wr_en", 64'(wr_en), 64'd1);
    wait_empty();

    // Register zero: handshake completes, nothing stored.
    push(5'd0, 32'd12);
    chk("r0_count", 64'(count), 64'd0);
    chk("r0_wr_en", 64'(wr_en), 64'd0);
    lookup_b = 5'd0;
    #1;
    chk("r0_hit_b", 64'(hit_b), 64'd0);
    tick(3);

    // Back-to-back stream keeps FIFO order.
    for (int i = 0; i < 4; i++) push(5'(7 + i), 32'(100 + i));
    wait_empty();

`ifdef WB_BYPASS_EN
    // Youngest match wins.
    drain_stall = 1'b1;
    push(5'd2, 32'd15);
    lookup_a = 5'd2;
    lookup_b = 5'd3;
    #1;
    chk("yng_hit_first", 64'({hit_a, hit_data_a}), {31'd0, 1'b1, 32'd15});
    push(5'd2, 32'd36);
    chk("yng_hit_a", 64'({hit_a, hit_data_a}), {31'd0, 1'b1, 32'd36});
    chk("yng_miss_b", 64'({hit_b, hit_data_b}), 64'd0);
    drain_stall = 1'b0;
    wait_empty();
    chk("yng_rf", 64'(rf[2]), 64'd36);

    // Fill to full, a fifth write is refused until a drain frees a slot.
    drain_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(3 + i), 32'(200 + i));
    chk("full_flag", 64'(full), 64'd1);
    chk("full_in_ready", 64'(u_if.in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    u_if.in_valid = 1'b1;
    u_if.in_addr = 5'd7;
    u_if.in_data = 32'd999;
    tick(2);
    u_if.in_valid = 1'b0;
    chk("full_reject_count", 64'(count), 64'd4);
    drain_stall = 1'b0;
    #1;
    chk("full_drain_in_ready", 64'(u_if.in_ready), 64'd0);
    tick(1);
    drain_stall = 1'b1;
    #1;
    chk("after_drain_in_ready", 64'(u_if.in_ready), 64'd1);
    chk("after_drain_count", 64'(count), 64'd3);
    drain_stall = 1'b0;
    wait_empty();

    // Simultaneous push/pop at count=2 across pointer wrap.
    drain_stall = 1'b1;
    push(5'd20, 32'd1);
    push(5'd21, 32'd2);
    drain_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(5'(22 + i), 32'(3 + i));
      chk("wrap_count", 64'(count), 64'd2);
    end
    wait_empty();
`endif

    // Asynchronous reset with entries pending.
    drain_stall = 1'b1;
    push(5'd9, 32'd33);
`ifdef WB_BYPASS_EN
    push(5'd10, 32'd34);
    push(5'd11, 32'd35);
    chk("pre_rst_count", 64'(count), 64'd3);
`else
    chk("pre_rst_count", 64'(count), 64'd1);
`endif
    lookup_a = 5'd9;
    drain_stall = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_flags", 64'({empty, full, u_if.in_ready}), 64'b101);
    chk("arst_wr", 64'({wr_en, wr_addr, wr_data}), 64'd0);
    chk("arst_hit_a", 64'({hit_a, hit_data_a}), 64'd0);
    tick(2);
    #3;
    rst_n = 1'b1;
    tick(1);
    push(5'd17, 32'd29);
    chk("post_rst_wr", 64'({wr_en, wr_addr, wr_data}), {26'd0, 1'b1, 5'd17, 32'd29});
    wait_empty();
    chk("post_rst_rf", 64'(rf[17]), 64'd29);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_buffer.md
# regfile_write_buffer

Write-back buffer that sits directly upstream of the 32×32 register file's write port (`Aw`/`Dw`/`WrEn`). It accepts register writes from the execute/write-back path through a valid/ready handshake and queues them in an in-order FIFO. It drains one entry per cycle into the register file. Two lookup ports let the operand-read path see the youngest pending write for an address before that write has landed in the register file.

## Interface
- `DEPTH`, default 4: number of FIFO entries; power of two, ≥2.
- `AW`, default 5: register address width.
- `DW`, default 32: register data width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: producer has a write to offer.
- `in_ready` out 1: buffer can accept; equals `!full`.
- `in_addr` in AW: destination register.
- `in_data` in DW: value to write.
- `drain_stall` in 1: when high, no entry drains this cycle.
- `wr_en` out 1: drives register file `WrEn`.
- `wr_addr` out AW: drives `Aw`.
- `wr_data` out DW: drives `Dw`.
- `lookup_a`, `lookup_b` in AW: addresses currently presented on read ports `Aa`/`Ab`.
- `hit_a`, `hit_b` out 1: a pending write to that address exists.
- `hit_data_a`, `hit_data_b` out DW: data of the youngest matching pending write.
- `count` out $clog2(DEPTH)+1: number of occupied entries.
- `empty`, `full` out 1: occupancy flags.

## Operation
- Storage: DEPTH entries of {addr, data}, plus a head pointer, a tail pointer and `count`.
- Enqueue: on a rising edge with `in_valid && in_ready` and `in_addr != 0`, the entry is written at tail, tail advances, and count increments.
- Writes to register 0 are accepted (handshake completes) and discarded; count is unchanged.
- Drain:
  - `wr_en = !empty && !drain_stall`.
  - `wr_addr`/`wr_data` are the head entry, combinationally.
  - On a rising edge with `wr_en` high, head advances and count decrements. The register file captures the same write on the same edge.
- Simultaneous enqueue and drain: count unchanged and both pointers advance.
- When full, `in_ready` is low even if a drain occurs in the same cycle; there is no pass-through.
- Pointers wrap modulo DEPTH.
- When `empty`, `wr_addr`/`wr_data` are 0.
- Lookup:
  - `hit_x` is high if any occupied entry has `addr == lookup_x` and `lookup_x != 0`.
  - `hit_data_x` is the data of the youngest such entry, measured from tail backward, and 0 when there is no hit.
  - Lookup is purely combinational on the current stored state. It does not see the same-cycle `in_*` write.
  - The entry on `wr_*` still counts as a hit in its drain cycle.
- Downstream operand select is `hit_x ? hit_data_x : D{a,b}`. This gives read-after-write ordering with no stall.
- Reset (asserted asynchronously): head=tail=0, count=0, `empty`=1, `full`=0, `in_ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `hit_*`=0, `hit_data_*`=0. Pending entries are lost.
- Reset released mid-operation: the first enqueue is accepted on the first rising edge after deassertion.

## Timing
- Enqueue-to-drain latency: an entry enqueued at edge N into an empty buffer drives `wr_en` during cycle N+1 and is written into the register file at edge N+1.
- Register-file readback becomes visible after edge N+1. Before that edge, `hit_x` covers the entry from edge N onward.
- Throughput: 1 enqueue and 1 drain per cycle sustained.
- `in_ready`, `full`, `empty` and `count` are functions of registered state only, with no combinational path from `in_valid`.
- `wr_en` depends combinationally on `drain_stall`.
- `hit_*` depend combinationally on `lookup_*`.

## Configuration
- `WB_BYPASS_EN` defined: lookup comparators and youngest-match priority logic are compiled in, as described above.
- `WB_BYPASS_EN` undefined:
  - Lookup logic is removed; `hit_a`/`hit_b` are tied 0 and `hit_data_*` are tied 0.
  - `in_ready = empty && !wr_en`, so at most one write is in flight. This keeps reads coherent without a bypass.

## Test plan
- Reset then write r2=42: single enqueue → `wr_en`=1 next cycle with `wr_addr`=2 and `wr_data`=42; register file reads 42 after that edge; count returns to 0.
- Youngest match: `drain_stall`=1; enqueue r2=15 then r2=36; lookup_a=2 → `hit_a`=1 and `hit_data_a`=36; release stall → drains 15 then 36 in order.
- Fill to full: stall, enqueue r3..r6 → `full`=1, `in_ready`=0, count=4; a 5th `in_valid` is not accepted; one drain → `in_ready`=1 the next cycle.
- Register zero: enqueue r0=12 → handshake completes, count stays 0, `wr_en` never asserts, lookup_b=0 gives `hit_b`=0.
- Simultaneous push/pop at count=2 with pointers wrapping past DEPTH-1 → count stays 2 and FIFO order is preserved across the wrap.
- Assert `rst_n`=0 asynchronously with count=3 → all outputs take reset values immediately, with no `wr_en` pulse; after release, r17=29 enqueues and drains normally.
